traffic_phase_arbiter: RTL and testbench

TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

---
 rtl/traffic_phase_arbiter.sv | 154 +++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter.sv
// Four-approach traffic phase FSM (ALL_RED/GREEN/YELLOW), round-robin grant; EMERGENCY_PREEMPT_EN adds preemption.
// Latency: req/emg_req act on the next rising edge; all outputs registered.
// Backpressure: none; demand is level-sampled every cycle with no latching.
module traffic_phase_arbiter #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] emg_req,
  output logic [2:0] light_path_left,
  output logic [2:0] light_path_right,
  output logic [2:0] light_straight,
  output logic [2:0] light_back,
  output logic [1:0] grant,
  output logic       phase_start
);

  localparam logic [8:0] GMIN = 9'(GREEN_MIN);
  localparam logic [8:0] GMAX = 9'(GREEN_MAX);
  localparam logic [8:0] YT   = 9'(YELLOW_T);
  localparam logic [8:0] ART  = 9'(ALLRED_T);

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [8:0] n;
  logic [1:0] grant_nxt;
  logic [1:0] rr_pick;
  logic [1:0] rr_idx;
  logic       rr_any;
  logic       others;
  logic       emg_any;
  logic [1:0] emg_idx;
  logic [2:0] lamp_nxt [4];

  // n is the 1-based count of cycles spent in the current state
  assign n = {1'b0, cnt} + 9'd1;

  always_comb begin
    rr_any  = |req;
    rr_pick = grant;
    rr_idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = grant + 2'(k);
      if (req[rr_idx]) begin
        rr_pick = rr_idx;
      end
    end
  end

  assign others = |(req & ~(4'b0001 << grant));

`ifdef EMERGENCY_PREEMPT_EN
  always_comb begin
    emg_any = |emg_req;
    emg_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emg_req[i]) begin
        emg_idx = 2'(i);
      end
    end
  end
`else
  logic emg_unused;
  assign emg_unused = ^emg_req;
  assign emg_any    = 1'b0;
  assign emg_idx    = 2'd0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ALL_RED: begin
        if (n >= ART) begin
          if (emg_any) begin
            state_nxt = GREEN;
            grant_nxt = emg_idx;
          end else if (rr_any) begin
            state_nxt = GREEN;
            grant_nxt = rr_pick;
          end
        end
      end
      GREEN: begin
        if (emg_any) begin
          // the emergency owner holds green indefinitely; anyone else yields at once
          if (emg_idx != grant) begin
            state_nxt = YELLOW;
          end
        end else if ((n >= GMAX) || ((n >= GMIN) && (others || !req[grant]))) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (n >= YT) begin
          state_nxt = ALL_RED;
        end
      end
      default: begin
        state_nxt = ALL_RED;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lamp_nxt[i] = 3'b100;
      if (2'(i) == grant_nxt) begin
        if (state_nxt == GREEN) begin
          lamp_nxt[i] = 3'b001;
        end else if (state_nxt == YELLOW) begin
          lamp_nxt[i] = 3'b010;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ALL_RED;
      cnt              <= 8'd0;
      grant            <= 2'd3;
      phase_start      <= 1'b0;
      light_path_left  <= 3'b100;
      light_path_right <= 3'b100;
      light_straight   <= 3'b100;
      light_back       <= 3'b100;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      phase_start <= (state_nxt == GREEN) && (state != GREEN);
      if (state_nxt != state) begin
        cnt <= 8'd0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      light_path_left  <= lamp_nxt[0];
      light_path_right <= lamp_nxt[1];
      light_straight   <= lamp_nxt[2];
      light_back       <= lamp_nxt[3];
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: phase-level reference model plus directed scenarios.
module tb_traffic_phase_arbiter;

  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
`ifdef EMERGENCY_PREEMPT_EN
  localparam bit EMG_ON = 1'b1;
`else
  localparam bit EMG_ON = 1'b0;
`endif

  localparam int M_RED = 0;
  localparam int M_GRN = 1;
  localparam int M_YEL = 2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] emg_req;
  logic [2:0] light_path_left, light_path_right, light_straight, light_back;
  logic [1:0] grant;
  logic       phase_start;

  traffic_phase_arbiter #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .emg_req(emg_req),
    .light_path_left(light_path_left), .light_path_right(light_path_right),
    .light_straight(light_straight), .light_back(light_back),
    .grant(grant), .phase_start(phase_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][2:0] lamps;
  assign lamps = {light_back, light_straight, light_path_right, light_path_left};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: which phase is shown, for how many cycles so far, and to whom.
  typedef struct {
    int ph;
    int age;
    int g;
  } mdl_t;

  mdl_t m;
  bit   m_valid = 1'b0;

  function automatic mdl_t step(mdl_t cur, logic r, logic [3:0] q, logic [3:0] e);
    mdl_t o;
    int   tgt;
    int   pick;
    bit   leave;
    o = cur;
    if (r) begin
      o.ph = M_RED; o.age = 1; o.g = 3;
      return o;
    end
    tgt = -1;
    for (int i = 3; i >= 0; i--) if (EMG_ON && e[i]) tgt = i;
    pick = -1;
    for (int k = 4; k >= 1; k--) if (q[(cur.g + k) % 4]) pick = (cur.g + k) % 4;
    leave = 1'b0;
    case (cur.ph)
      M_RED: begin
        if (cur.age >= ALLRED_T && (tgt >= 0 || pick >= 0)) begin
          o.ph = M_GRN; o.age = 1; o.g = (tgt >= 0) ? tgt : pick;
          return o;
        end
      end
      M_GRN: begin
        if (tgt >= 0) leave = (tgt != cur.g);
        else leave = (cur.age >= GREEN_MAX) ||
                     (cur.age >= GREEN_MIN && (((q & ~(4'b0001 << cur.g)) != 4'b0) || !q[cur.g]));
        if (leave) begin
          o.ph = M_YEL; o.age = 1;
          return o;
        end
      end
      default: begin
        if (cur.age >= YELLOW_T) begin
          o.ph = M_RED; o.age = 1;
          return o;
        end
      end
    endcase
    o.age = cur.age + 1;
    return o;
  endfunction

  function automatic logic [2:0] exp_lamp(mdl_t cur, int i);
    if (cur.ph == M_GRN && cur.g == i) return 3'b001;
    if (cur.ph == M_YEL && cur.g == i) return 3'b010;
    return 3'b100;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst, req, emg_req);
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int nonred;
      bit legal;
      nonred = 0;
      legal  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model_lamp%0d", i), 32'(lamps[i]), 32'(exp_lamp(m, i)));
        if (lamps[i] != 3'b100) nonred++;
        if (lamps[i] != 3'b001 && lamps[i] != 3'b010 && lamps[i] != 3'b100) legal = 1'b0;
      end
      chk("model_grant", 32'(grant), 32'(m.g));
      chk("model_phase_start", 32'(phase_start), 32'(m.ph == M_GRN && m.age == 1));
      chk("excl_nonred_le1", 32'(nonred <= 1), 32'd1);
      chk("lamp_code_legal", 32'(legal), 32'd1);
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic reset_for(input int c);
    rst = 1'b1;
    cyc(c);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] r;
    int         n;
  } vec_t;

  vec_t tbl [6];
  int   ps_seen;

  initial begin
    rst = 1'b1; req = 4'b0000; emg_req = 4'b0000;
    tbl[0] = '{4'b1001, 30};
    tbl[1] = '{4'b0100, 6};
    tbl[2] = '{4'b0000, 10};
    tbl[3] = '{4'b0110, 15};
    tbl[4] = '{4'b1000, 5};
    tbl[5] = '{4'b0011, 25};

    // lone requester on left: full GREEN_MAX then yellow, all-red, repeat
    req = 4'b0001;
    reset_for(2);
    chk("rst_left", 32'(light_path_left), 32'h4);
    chk("rst_back", 32'(light_back), 32'h4);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_ps", 32'(phase_start), 32'd0);
    cyc(1);  chk("a_g1_left", 32'(light_path_left), 32'h1); chk("a_g1_ps", 32'(phase_start), 32'd1);
    cyc(1);  chk("a_g2_ps", 32'(phase_start), 32'd0);
    cyc(10); chk("a_g12_left", 32'(light_path_left), 32'h1);
    cyc(1);  chk("a_y1_left", 32'(light_path_left), 32'h2);
    cyc(1);  chk("a_y2_left", 32'(light_path_left), 32'h2);
    cyc(1);  chk("a_ar_left", 32'(light_path_left), 32'h4); chk("a_ar_grant", 32'(grant), 32'd0);
    cyc(1);  chk("a_regrant_left", 32'(light_path_left), 32'h1); chk("a_regrant_ps", 32'(phase_start), 32'd1);
    cyc(20);

    // idle: nothing requested
    req = 4'b0000;
    reset_for(2);
    ps_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (phase_start) ps_seen++;
    end
    chk("idle_ps_count", 32'(ps_seen), 32'd0);
    chk("idle_lamps", 32'(lamps), 32'h924);

    // left + straight alternate at GREEN_MIN
    req = 4'b0101;
    reset_for(2);
    cyc(1); chk("c_g1_grant", 32'(grant), 32'd0); chk("c_g1_left", 32'(light_path_left), 32'h1);
    cyc(3); chk("c_g4_left", 32'(light_path_left), 32'h1);
    cyc(1); chk("c_y1_left", 32'(light_path_left), 32'h2);
    cyc(2); chk("c_ar_left", 32'(light_path_left), 32'h4);
    cyc(1); chk("c_s_grant", 32'(grant), 32'd2); chk("c_s_straight", 32'(light_straight), 32'h1);
            chk("c_s_ps", 32'(phase_start), 32'd1);
    cyc(4); chk("c_s_yellow", 32'(light_straight), 32'h2);
    cyc(3); chk("c_back_grant", 32'(grant), 32'd0); chk("c_back_left", 32'(light_path_left), 32'h1);
    cyc(10);

    // reset mid-green abandons the phase without yellow
    req = 4'b0010;
    reset_for(2);
    cyc(3); chk("d_g3_grant", 32'(grant), 32'd1); chk("d_g3_right", 32'(light_path_right), 32'h1);
    rst = 1'b1;
    cyc(1); chk("d_rst_right", 32'(light_path_right), 32'h4); chk("d_rst_grant", 32'(grant), 32'd3);
            chk("d_rst_lamps", 32'(lamps), 32'h924);
    rst = 1'b0;
    cyc(1); chk("d_after_right", 32'(light_path_right), 32'h1); chk("d_after_ps", 32'(phase_start), 32'd1);
    cyc(8);

    // lone back requester: first search wraps to 3, re-granted after yellow + all-red
    req = 4'b1000;
    reset_for(2);
    cyc(1);  chk("w_g_grant", 32'(grant), 32'd3); chk("w_g_back", 32'(light_back), 32'h1);
    cyc(15); chk("w_regrant_back", 32'(light_back), 32'h1); chk("w_regrant_ps", 32'(phase_start), 32'd1);

    // directed req table, checked by the model every cycle
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].r;
      cyc(tbl[i].n);
    end

`ifdef EMERGENCY_PREEMPT_EN
    req = 4'b0001; emg_req = 4'b0000;
    reset_for(2);
    cyc(2); emg_req = 4'b1000;
    cyc(1); chk("e_left_yellow", 32'(light_path_left), 32'h2);
    cyc(2); chk("e_allred", 32'(lamps), 32'h924);
    cyc(1); chk("e_grant", 32'(grant), 32'd3); chk("e_back_green", 32'(light_back), 32'h1);
    cyc(15); chk("e_back_hold", 32'(light_back), 32'h1);
    emg_req = 4'b0000;
    cyc(1); chk("e_back_yellow", 32'(light_back), 32'h2);
    cyc(10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
